// File: rtl/alu_issue_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// alu_issue_ctrl_pkg
// Shared definitions for the ALU issue/writeback controller and the ALU:
//   - ALU select codes (5-bit)
//   - control FSM state encoding
//   - debug view of the controller's internal state
// -----------------------------------------------------------------------------
package alu_issue_ctrl_pkg;

  localparam int OP_W = 5;

  localparam logic [OP_W-1:0] OP_ADD = 5'd0;
  localparam logic [OP_W-1:0] OP_SUB = 5'd1;
  localparam logic [OP_W-1:0] OP_DIV = 5'd2;
  localparam logic [OP_W-1:0] OP_AND = 5'd3;
  localparam logic [OP_W-1:0] OP_OR  = 5'd4;
  localparam logic [OP_W-1:0] OP_XOR = 5'd5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_DIV  = 2'd2,
    ST_WB   = 2'd3
  } state_t;

  // Observation bundle exported by the controller.
  typedef struct packed {
    state_t state;
    logic   div_busy;
  } dbg_t;

  // Only add and subtract update the carry flag.
  function automatic logic op_sets_carry(input logic [OP_W-1:0] op);
    return (op == OP_ADD) || (op == OP_SUB);
  endfunction

endpackage

// File: rtl/alu_issue_ctrl_seq_divider.sv
// -----------------------------------------------------------------------------
// alu_issue_ctrl_seq_divider
// Unsigned restoring divider, one quotient bit per clock, WORD_SIZE iterations.
//
// Ports:
//   clk, clr_n   clock / asynchronous active-low reset
//   start        load dividend/divisor and begin (ignored when not idle)
//   dividend     numerator, sampled on start
//   divisor      denominator, sampled on start (caller guarantees non-zero)
//   busy         iterations in progress
//   done         high during the final iteration cycle: the quotient is
//                complete after the clock edge that ends this cycle
//   quotient     quotient register (remainder is kept internally only)
// -----------------------------------------------------------------------------
module alu_issue_ctrl_seq_divider #(
  parameter int WORD_SIZE = 8
) (
  input  logic                 clk,
  input  logic                 clr_n,
  input  logic                 start,
  input  logic [WORD_SIZE-1:0] dividend,
  input  logic [WORD_SIZE-1:0] divisor,
  output logic                 busy,
  output logic                 done,
  output logic [WORD_SIZE-1:0] quotient
);

  localparam int CW = (WORD_SIZE > 1) ? $clog2(WORD_SIZE) : 1;

  logic [WORD_SIZE-1:0] rem_q;
  logic [WORD_SIZE-1:0] quo_q;
  logic [WORD_SIZE-1:0] divisor_q;
  logic [CW-1:0]        cnt_q;
  logic                 busy_q;

  // Partial remainder shifted left with the next dividend bit, and the trial
  // subtraction. A set top bit of trial means the subtraction went negative,
  // so the shifted value is kept (restored) and the quotient bit is 0.
  logic [WORD_SIZE:0] shifted;
  logic [WORD_SIZE:0] trial;

  always_comb begin
    shifted = {rem_q, quo_q[WORD_SIZE-1]};
    trial   = shifted - {1'b0, divisor_q};
  end

  assign busy     = busy_q;
  assign done     = busy_q && (cnt_q == CW'(WORD_SIZE - 1));
  assign quotient = quo_q;

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      rem_q     <= '0;
      quo_q     <= '0;
      divisor_q <= '0;
      cnt_q     <= '0;
      busy_q    <= 1'b0;
    end else if (start && !busy_q) begin
      rem_q     <= '0;
      quo_q     <= dividend;
      divisor_q <= divisor;
      cnt_q     <= '0;
      busy_q    <= 1'b1;
    end else if (busy_q) begin
      // The dividend shifts out of the top of quo_q while quotient bits
      // shift in at the bottom.
      if (trial[WORD_SIZE]) begin
        rem_q <= shifted[WORD_SIZE-1:0];
        quo_q <= {quo_q[WORD_SIZE-2:0], 1'b0};
      end else begin
        rem_q <= trial[WORD_SIZE-1:0];
        quo_q <= {quo_q[WORD_SIZE-2:0], 1'b1};
      end
      cnt_q <= cnt_q + CW'(1);
      if (done) begin
        busy_q <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/alu_issue_ctrl.sv
// -----------------------------------------------------------------------------
// alu_issue_ctrl
// Issue/writeback controller for the datapath ALU. Owns a small register file,
// accepts one operation at a time, presents registered operands and select to
// the external combinational ALU, captures its result/carry and writes back.
// Divide is executed locally by a sequential divider; the ALU is not used.
//
// Ports:
//   clk, clr_n                 clock / asynchronous active-low reset
//   in_valid, in_ready         operation handshake
//   in_op, in_ra, in_rb, in_rd select code, sources, destination
//   ld_en, ld_addr, ld_data    host register preload (any state)
//   rd_addr, rd_data           combinational register observation port
//   alu_a, alu_b, alu_sel      registered ALU inputs
//   alu_out, alu_carry         ALU result and carry-out
//   wb_valid, wb_addr, wb_data writeback (wb_valid is a one-cycle pulse)
//   carry_flag                 carry of the last add/sub
//   dz_flag                    last divide had a zero divisor
//   dbg                        FSM state and divider activity
//
// Handshake: an operation transfers on a rising edge where in_valid and
// in_ready are both high. in_ready is high only in IDLE and does not depend on
// in_valid; the op fields must be stable while in_valid is high.
// -----------------------------------------------------------------------------
module alu_issue_ctrl
  import alu_issue_ctrl_pkg::*;
#(
  parameter int WORD_SIZE = 8,
  parameter int NUM_REGS  = 8,
  parameter int AW        = $clog2(NUM_REGS)
) (
  input  logic                 clk,
  input  logic                 clr_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [OP_W-1:0]      in_op,
  input  logic [AW-1:0]        in_ra,
  input  logic [AW-1:0]        in_rb,
  input  logic [AW-1:0]        in_rd,
  input  logic                 ld_en,
  input  logic [AW-1:0]        ld_addr,
  input  logic [WORD_SIZE-1:0] ld_data,
  input  logic [AW-1:0]        rd_addr,
  output logic [WORD_SIZE-1:0] rd_data,
  output logic [WORD_SIZE-1:0] alu_a,
  output logic [WORD_SIZE-1:0] alu_b,
  output logic [OP_W-1:0]      alu_sel,
  input  logic [WORD_SIZE-1:0] alu_out,
  input  logic                 alu_carry,
  output logic                 wb_valid,
  output logic [AW-1:0]        wb_addr,
  output logic [WORD_SIZE-1:0] wb_data,
  output logic                 carry_flag,
  output logic                 dz_flag,
  output dbg_t                 dbg
);

  logic [WORD_SIZE-1:0] regfile [NUM_REGS];

  state_t               state_q;
  state_t               state_d;
  logic [WORD_SIZE-1:0] alu_a_q;
  logic [WORD_SIZE-1:0] alu_b_q;
  logic [OP_W-1:0]      alu_sel_q;
  logic [AW-1:0]        rd_q;
  logic [WORD_SIZE-1:0] result_q;
  logic                 div_path_q;  // result comes from the divider
  logic                 carry_q;
  logic                 dz_q;

  logic                 accept;
  logic                 div_start;
  logic                 div_busy;
  logic                 div_done;
  logic [WORD_SIZE-1:0] div_quotient;
  logic [WORD_SIZE-1:0] src_a;
  logic [WORD_SIZE-1:0] src_b;

  assign src_a = regfile[in_ra];
  assign src_b = regfile[in_rb];

  alu_issue_ctrl_seq_divider #(
    .WORD_SIZE (WORD_SIZE)
  ) u_div (
    .clk      (clk),
    .clr_n    (clr_n),
    .start    (div_start),
    .dividend (src_a),
    .divisor  (src_b),
    .busy     (div_busy),
    .done     (div_done),
    .quotient (div_quotient)
  );

  // ---------------------------------------------------------------------------
  // FSM next state and handshake outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    wb_valid  = 1'b0;
    accept    = 1'b0;
    div_start = 1'b0;
    case (state_q)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          accept = 1'b1;
          // A zero divisor takes the short path and is resolved in EXEC.
          if (in_op == OP_DIV && src_b != '0) begin
            div_start = 1'b1;
            state_d   = ST_DIV;
          end else begin
            state_d = ST_EXEC;
          end
        end
      end
      ST_EXEC: state_d = ST_WB;
      ST_DIV: begin
        if (div_done) begin
          state_d = ST_WB;
        end
      end
      ST_WB: begin
        wb_valid = 1'b1;
        state_d  = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Datapath registers and register file
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regfile[i] <= '0;
      end
      alu_a_q    <= '0;
      alu_b_q    <= '0;
      alu_sel_q  <= '0;
      rd_q       <= '0;
      result_q   <= '0;
      div_path_q <= 1'b0;
      carry_q    <= 1'b0;
      dz_q       <= 1'b0;
    end else begin
      if (accept) begin
        alu_a_q    <= src_a;
        alu_b_q    <= src_b;
        alu_sel_q  <= in_op;
        rd_q       <= in_rd;
        div_path_q <= div_start;
      end

      if (state_q == ST_EXEC) begin
        if (op_sets_carry(alu_sel_q)) begin
          carry_q <= alu_carry;
        end
        // Reaching EXEC with a divide means the divisor was zero.
        if (alu_sel_q == OP_DIV) begin
          result_q <= '1;
          dz_q     <= 1'b1;
        end else begin
          result_q <= alu_out;
        end
      end

      if (state_q == ST_DIV && div_done) begin
        dz_q <= 1'b0;
      end

      // Host preload first so a same-cycle writeback to the same register
      // overrides it.
      if (ld_en) begin
        regfile[ld_addr] <= ld_data;
      end
      if (state_q == ST_WB) begin
        regfile[rd_q] <= wb_data;
      end
    end
  end

  assign alu_a      = alu_a_q;
  assign alu_b      = alu_b_q;
  assign alu_sel    = alu_sel_q;
  assign wb_addr    = rd_q;
  assign wb_data    = div_path_q ? div_quotient : result_q;
  assign carry_flag = carry_q;
  assign dz_flag    = dz_q;
  assign rd_data    = regfile[rd_addr];

  assign dbg.state    = state_q;
  assign dbg.div_busy = div_busy;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// -----------------------------------------------------------------------------
// tb_alu_issue_ctrl
// Directed and randomized checks of alu_issue_ctrl against a reference model
// of the register file, flags and expected writebacks.
// -----------------------------------------------------------------------------
module tb_alu_issue_ctrl;
  import alu_issue_ctrl_pkg::*;

  localparam int W  = 8;
  localparam int N  = 8;
  localparam int AW = 3;

  logic            clk;
  logic            clr_n;
  logic            in_valid;
  logic            in_ready;
  logic [OP_W-1:0] in_op;
  logic [AW-1:0]   in_ra, in_rb, in_rd;
  logic            ld_en;
  logic [AW-1:0]   ld_addr;
  logic [W-1:0]    ld_data;
  logic [AW-1:0]   rd_addr;
  logic [W-1:0]    rd_data;
  logic [W-1:0]    alu_a, alu_b;
  logic [OP_W-1:0] alu_sel;
  logic [W-1:0]    alu_out;
  logic            alu_carry;
  logic            wb_valid;
  logic [AW-1:0]   wb_addr;
  logic [W-1:0]    wb_data;
  logic            carry_flag;
  logic            dz_flag;
  dbg_t            dbg;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [W-1:0] ref_rf [N];
  logic         ref_carry;
  logic         ref_dz;
  logic [W-1:0] exp_q [$];

  alu_issue_ctrl #(.WORD_SIZE(W), .NUM_REGS(N), .AW(AW)) dut (
    .clk        (clk),
    .clr_n      (clr_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_op      (in_op),
    .in_ra      (in_ra),
    .in_rb      (in_rb),
    .in_rd      (in_rd),
    .ld_en      (ld_en),
    .ld_addr    (ld_addr),
    .ld_data    (ld_data),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_sel    (alu_sel),
    .alu_out    (alu_out),
    .alu_carry  (alu_carry),
    .wb_valid   (wb_valid),
    .wb_addr    (wb_addr),
    .wb_data    (wb_data),
    .carry_flag (carry_flag),
    .dz_flag    (dz_flag),
    .dbg        (dbg)
  );

  // ---------------------------------------------------------------------------
  // Clock and ALU stand-in (sub carry = borrow; divide select returns junk)
  // ---------------------------------------------------------------------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    alu_out   = alu_a;
    alu_carry = 1'b0;
    case (alu_sel)
      OP_ADD: {alu_carry, alu_out} = {1'b0, alu_a} + {1'b0, alu_b};
      OP_SUB: {alu_carry, alu_out} = {1'b0, alu_a} - {1'b0, alu_b};
      OP_DIV: begin alu_out = 8'h5A; alu_carry = 1'b1; end
      OP_AND: alu_out = alu_a & alu_b;
      OP_OR:  alu_out = alu_a | alu_b;
      OP_XOR: alu_out = alu_a ^ alu_b;
      default: alu_out = alu_a;
    endcase
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input int a, input logic [W-1:0] d);
    ld_en   = 1'b1;
    ld_addr = AW'(a);
    ld_data = d;
    step();
    ld_en     = 1'b0;
    ref_rf[a] = d;
  endtask

  task automatic read_check(input string tag, input int a);
    rd_addr = AW'(a);
    #1;
    check(tag, 32'(rd_data), 32'(ref_rf[a]));
  endtask

  task automatic send(input logic [OP_W-1:0] op, input int ra, input int rb, input int rd);
    int n;
    n = 0;
    while (in_ready !== 1'b1 && n < 50) begin
      step();
      n++;
    end
    check("ready_before_send", 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    in_op    = op;
    in_ra    = AW'(ra);
    in_rb    = AW'(rb);
    in_rd    = AW'(rd);
    step();
    in_valid = 1'b0;
  endtask

  // Called one cycle after the accept edge. ld_mode: 0 none, 1 preload in the
  // first cycle after accept, 2 preload during the writeback cycle.
  task automatic complete(input logic [OP_W-1:0] op, input int ra, input int rb, input int rd,
                          input int ld_mode, input int ld_a, input logic [W-1:0] ld_d);
    logic [W-1:0] a, b, res, exp;
    logic [W:0]   wide;
    logic         nc, nd;
    int           lat, cyc;
    a = ref_rf[ra];
    b = ref_rf[rb];
    nc = ref_carry;
    nd = ref_dz;
    lat = 2;
    case (op)
      OP_ADD: begin wide = {1'b0, a} + {1'b0, b}; res = wide[W-1:0]; nc = wide[W]; end
      OP_SUB: begin res = a - b; nc = (a < b); end
      OP_DIV: begin
        if (b == 0) begin res = '1; nd = 1'b1; end
        else begin res = a / b; nd = 1'b0; lat = W + 1; end
      end
      OP_AND: res = a & b;
      OP_OR:  res = a | b;
      OP_XOR: res = a ^ b;
      default: res = a;
    endcase
    exp_q.push_back(res);

    check("ready_low_after_accept", 32'(in_ready), 32'd0);
    check("alu_a", 32'(alu_a), 32'(a));
    check("alu_b", 32'(alu_b), 32'(b));
    check("alu_sel", 32'(alu_sel), 32'(op));

    if (ld_mode == 1) begin
      ld_en = 1'b1; ld_addr = AW'(ld_a); ld_data = ld_d;
    end
    cyc = 1;
    while (wb_valid !== 1'b1 && cyc < 40) begin
      step();
      if (ld_en) begin
        ld_en = 1'b0;
        ref_rf[ld_a] = ld_d;
      end
      cyc++;
      if (wb_valid !== 1'b1) check("ready_low_busy", 32'(in_ready), 32'd0);
    end
    check("wb_latency", 32'(cyc), 32'(lat));
    check("wb_addr", 32'(wb_addr), 32'(rd));
    exp = exp_q.pop_front();
    check("wb_data", 32'(wb_data), 32'(exp));

    if (ld_mode == 2) begin
      ld_en = 1'b1; ld_addr = AW'(ld_a); ld_data = ld_d;
    end
    step();
    if (ld_en) begin
      ld_en = 1'b0;
      ref_rf[ld_a] = ld_d;
    end
    ref_rf[rd] = res;  // writeback wins over a same-cycle preload
    ref_carry  = nc;
    ref_dz     = nd;
    check("wb_pulse_ends", 32'(wb_valid), 32'd0);
    check("carry_flag", 32'(carry_flag), 32'(ref_carry));
    check("dz_flag", 32'(dz_flag), 32'(ref_dz));
    read_check("rf_dest", rd);
  endtask

  task automatic run_op(input logic [OP_W-1:0] op, input int ra, input int rb, input int rd,
                        input int ld_mode, input int ld_a, input logic [W-1:0] ld_d);
    send(op, ra, rb, rd);
    complete(op, ra, rb, rd, ld_mode, ld_a, ld_d);
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    logic [OP_W-1:0] rop;
    int r, lm;

    clr_n = 1'b0; in_valid = 1'b0; in_op = '0; in_ra = '0; in_rb = '0; in_rd = '0;
    ld_en = 1'b0; ld_addr = '0; ld_data = '0; rd_addr = '0;
    for (int i = 0; i < N; i++) ref_rf[i] = '0;
    ref_carry = 1'b0;
    ref_dz    = 1'b0;

    // Reset values
    step();
    step();
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_state", 32'(dbg.state), 32'(ST_IDLE));
    check("rst_wb_valid", 32'(wb_valid), 32'd0);
    check("rst_wb_addr", 32'(wb_addr), 32'd0);
    check("rst_wb_data", 32'(wb_data), 32'd0);
    check("rst_alu_a", 32'(alu_a), 32'd0);
    check("rst_alu_b", 32'(alu_b), 32'd0);
    check("rst_alu_sel", 32'(alu_sel), 32'd0);
    check("rst_carry", 32'(carry_flag), 32'd0);
    check("rst_dz", 32'(dz_flag), 32'd0);
    clr_n = 1'b1;
    step();
    for (int i = 0; i < N; i++) read_check("rst_rf", i);

    // Add, no carry: 0x2A + 0x15 = 0x3F
    load(1, 8'h2A);
    load(2, 8'h15);
    run_op(OP_ADD, 1, 2, 3, 0, 0, 8'h00);

    // Add with carry, then xor leaves carry set
    load(1, 8'hF0);
    load(2, 8'h20);
    run_op(OP_ADD, 1, 2, 4, 0, 0, 8'h00);
    run_op(OP_XOR, 1, 2, 7, 0, 0, 8'h00);

    // Subtract both ways (borrow, then none)
    run_op(OP_SUB, 2, 1, 6, 0, 0, 8'h00);
    run_op(OP_SUB, 1, 2, 6, 0, 0, 8'h00);

    // Divide 200 / 7 = 28, WORD_SIZE+1 cycle latency
    load(1, 8'hC8);
    load(2, 8'h07);
    run_op(OP_DIV, 1, 2, 5, 0, 0, 8'h00);

    // Divide by zero, then a valid divide clears dz
    load(2, 8'h00);
    run_op(OP_DIV, 1, 2, 6, 0, 0, 8'h00);
    load(2, 8'h07);
    run_op(OP_DIV, 1, 2, 6, 0, 0, 8'h00);

    // Preload to destination during writeback: writeback wins
    load(1, 8'h11);
    load(2, 8'h22);
    run_op(OP_ADD, 1, 2, 3, 2, 3, 8'h55);

    // Preload to source right after accept: in-flight op keeps old operand
    run_op(OP_ADD, 1, 2, 4, 1, 1, 8'h99);
    read_check("rf_src_after_load", 1);
    run_op(OP_DIV, 1, 2, 5, 1, 2, 8'h03);
    read_check("rf_src_after_div_load", 2);

    // Randomized operations
    for (int k = 0; k < 40; k++) begin
      r = $urandom_range(0, 2);
      for (int j = 0; j < r; j++) begin
        load($urandom_range(0, N - 1),
             ($urandom_range(0, 5) == 0) ? 8'h00 : W'($urandom_range(0, 255)));
      end
      r = $urandom_range(0, 9);
      rop = (r <= 5) ? OP_W'(r) : OP_W'($urandom_range(6, 31));
      lm = $urandom_range(0, 2);
      run_op(rop, $urandom_range(0, N - 1), $urandom_range(0, N - 1), $urandom_range(0, N - 1),
             lm, $urandom_range(0, N - 1), W'($urandom_range(0, 255)));
    end

    // Reset in the fourth divide cycle
    load(1, 8'hC8);
    load(2, 8'h07);
    send(OP_DIV, 1, 2, 5);
    repeat (3) step();
    clr_n = 1'b0;
    #1;
    for (int i = 0; i < N; i++) ref_rf[i] = '0;
    ref_carry = 1'b0;
    ref_dz    = 1'b0;
    check("mid_rst_in_ready", 32'(in_ready), 32'd1);
    check("mid_rst_wb_valid", 32'(wb_valid), 32'd0);
    check("mid_rst_alu_a", 32'(alu_a), 32'd0);
    read_check("mid_rst_rf1", 1);
    // Request held through reset
    in_valid = 1'b1; in_op = OP_XOR; in_ra = 3'd1; in_rb = 3'd2; in_rd = 3'd6;
    for (int i = 0; i < 10; i++) begin
      step();
      check("rst_no_wb", 32'(wb_valid), 32'd0);
    end
    clr_n = 1'b1;
    step();
    in_valid = 1'b0;
    complete(OP_XOR, 1, 2, 6, 0, 0, 8'h00);

    for (int i = 0; i < N; i++) read_check("final_rf", i);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_issue_ctrl.md
Name: alu_issue_ctrl

Overview:
- Issue/writeback side of the datapath ALU. Owns a small operand register file and accepts operations over a valid/ready handshake.
- Drives registered operands and the select code to the combinational ALU, captures the result and carry, and writes back to a destination register.
- Executes divide (op 2) itself as a multi-cycle restoring divider; the ALU is never used for divide.

Parameters:
- WORD_SIZE, 8, operand/result width
- NUM_REGS, 8, register file depth (power of two, >=2)
- AW, $clog2(NUM_REGS), register address width (derived)

Ports:
- clk  in  1  single clock, rising edge
- clr_n  in  1  asynchronous active-low reset
- in_valid  in  1  operation request valid
- in_ready  out  1  block can accept (high only in IDLE)
- in_op  in  5  ALU select code: 0 add, 1 sub, 2 div, 3 and, 4 or, 5 xor, others pass A
- in_ra, in_rb, in_rd  in  AW each  source A, source B, destination
- ld_en  in  1  host register preload strobe
- ld_addr  in  AW  preload address
- ld_data  in  WORD_SIZE  preload data
- rd_addr  in  AW  observation read address
- rd_data  out  WORD_SIZE  combinational read of regfile[rd_addr]
- alu_a, alu_b  out  WORD_SIZE  registered ALU operands
- alu_sel  out  5  registered ALU select
- alu_out  in  WORD_SIZE  ALU result (combinational from alu_a/b/sel)
- alu_carry  in  1  ALU carry-out
- wb_valid  out  1  one-cycle pulse in the writeback cycle
- wb_addr  out  AW  destination of writeback
- wb_data  out  WORD_SIZE  written value
- carry_flag  out  1  sticky-until-overwritten carry from last add/sub
- dz_flag  out  1  set by last divide if divisor zero, cleared by next divide

Behaviour:
- Reset (clr_n low, async): state IDLE; all registers, alu_a/b/sel, wb_*, carry_flag, dz_flag = 0; in_ready = 1 once state is IDLE.
- States: IDLE, EXEC, DIV, WB.
- IDLE: in_ready=1. On in_valid&in_ready, capture regfile[ra]/[rb] into alu_a/alu_b and latch op and rd. Go to DIV if op==2 and B!=0, otherwise EXEC. op==2 with B==0 goes to EXEC, but the ALU output is ignored.
- EXEC (1 cycle): alu_out/alu_carry are sampled at the end of the cycle. For op 0/1, carry_flag <= alu_carry; other ops leave it unchanged. For div-by-zero, result = all ones and dz_flag <= 1. Then go to WB.
- DIV: restoring divide, one quotient bit per cycle, exactly WORD_SIZE cycles. Quotient is the result; remainder is discarded. dz_flag <= 0. Then go to WB.
- WB (1 cycle): wb_valid=1 with wb_addr/wb_data; regfile[rd] <= result at the end of the cycle. Next state IDLE.
- Latency, accept edge = cycle 0: non-div wb_valid in cycle 2; div wb_valid in cycle WORD_SIZE+1.
- Throughput: one non-div op per 3 cycles.
- Operands are captured at accept. Later ld_en writes do not affect an in-flight op.
- ld_en is allowed in any state. If ld_en and WB target the same register in the same cycle, WB wins.
- rd_data reflects writes from the next cycle onward; no bypass.
- Arithmetic is modulo 2^WORD_SIZE; the carry comes from the ALU only.
- Reset mid-op: abort immediately, no writeback, regfile cleared.

Decomposition:
- Shared package: op-code localparams (OP_ADD=0, OP_SUB=1, OP_DIV=2, OP_AND=3, OP_OR=4, OP_XOR=5) and the state enum, reused by the ALU and the control unit.
- One natural sub-module: seq_divider (start/busy/done, WORD_SIZE iterations, quotient out). The regfile stays inline.

Test Plan:
- Load r1=0x2A, r2=0x15; issue add ra=1 rb=2 rd=3 -> alu_a=0x2A, alu_b=0x15, alu_sel=0 in cycle 1; wb_valid cycle 2 with data 0x3F; r3=0x3F; carry_flag=0.
- r1=0xF0, r2=0x20, add rd=4 -> r4=0x10, carry_flag=1. Then xor r1,r2 -> 0xD0, carry_flag stays 1.
- r1=200 (0xC8), r2=7, div rd=5 -> wb_valid exactly 9 cycles after accept, r5=28 (0x1C), dz_flag=0, in_ready low throughout.
- Div with r2=0 -> wb_valid cycle 2, data 0xFF, dz_flag=1. A subsequent valid div clears dz_flag.
- ld_en to rd=3 during the WB of an op targeting r3 -> op result retained. ld_en to ra during EXEC -> result uses the old value.
- Assert clr_n low in DIV cycle 4 -> no wb_valid, all regs 0, in_ready=1 after release. An op with in_valid held through reset is accepted on the first clock after release.
